// File: rtl/fxp_mul_arb_if.sv
// Request/result bundle between four requesters, one consumer and the
// fixed-point multiplier arbiter.
interface fxp_mul_arb_if;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ready;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/fxp_mul_arb.sv
// Round-robin arbiter feeding a single signed Q4.4 multiplier that returns a
// rounded 8-bit integer product; one operation in flight at a time.
module fxp_mul_arb (
    input  logic              clk,
    input  logic              rst,
    fxp_mul_arb_if.slave      bus,
    output logic [7:0]        ops_done
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  last_grant;
    logic [1:0]  cand;
    logic [1:0]  grant_idx;
    logic        grant_found;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [1:0]  op_id;
    logic [7:0]  mag_a;
    logic [7:0]  mag_b;
    logic [15:0] prod;
    logic [7:0]  rounded;
    logic [7:0]  product;

    // 0x80 negates to 0x80, which read unsigned is the correct magnitude 128.
    assign mag_a   = op_a[7] ? (~op_a + 8'd1) : op_a;
    assign mag_b   = op_b[7] ? (~op_b + 8'd1) : op_b;
    assign prod    = 16'(mag_a) * 16'(mag_b);
    assign rounded = prod[15:8] + 8'(prod[7]);
    assign product = (op_a[7] ^ op_b[7]) ? (~rounded + 8'd1) : rounded;

    // Search starts one past the last winner and wraps through all four.
    always_comb begin
        // NOTE: every variable gets a default before any branch so none infers a latch.
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = 4'b0000;
        case (state)
            IDLE: begin
                if (grant_found && !rst) begin
                    bus.req_ready = 4'b0001 << grant_idx;
                    state_next    = MUL;
                end
            end
            MUL:  state_next = RESP;
            RESP: if (bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 2'd3;
            op_a          <= 8'h00;
            op_b          <= 8'h00;
            op_id         <= 2'd0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= 8'h00;
            bus.res_id    <= 2'd0;
            ops_done      <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a       <= bus.req_a[8*grant_idx +: 8];
                        op_b       <= bus.req_b[8*grant_idx +: 8];
                        op_id      <= grant_idx;
                        last_grant <= grant_idx;
                    end
                end
                MUL: begin
                    bus.res_data  <= product;
                    bus.res_id    <= op_id;
                    bus.res_valid <= 1'b1;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        ops_done      <= ops_done + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
